// File: rtl/fe_next_pc_gen.sv
// ----------------------------------------------------------------------------
// fe_next_pc_gen
//
// Front-end next-PC generator with a speculative-branch checkpoint queue.
// It owns the fetch PC register. Fetch is redirected on decode-time taken
// branches and on backend mispredicts. For every speculative branch, the
// alternate (not-chosen) PC is saved. When that branch resolves as
// mispredicted, the saved PC is restored.
//
// Optional build macro: FE_NEXT_PC_STATS_EN
//   Adds saturating 16-bit counters for speculative pushes and mispredict pops.
//
// Ports
//   clk_i, reset_n_i      clock and synchronous active-low reset
//   fetch_v_o             fetch_pc_o is valid (1 from the first cycle after reset)
//   fetch_ready_i         fetch/I-cache accepts fetch_pc_o
//   fetch_pc_o            registered fetch PC
//   dec_v_i/dec_ready_o   handshake for the branch-control result bundle
//   dec_pc_i              PC of the decoded instruction
//   take_branch_i         static take decision
//   speculative_i         decision needs a checkpoint
//   branch_target_i       decoded branch target
//   resolve_v_i           backend resolves the oldest speculative branch
//   resolve_mispredict_i  that branch was mispredicted
//   flush_o               combinational kill of younger front-end state
//   spec_count_o          checkpoint queue occupancy
//   stat_spec_o           (FE_NEXT_PC_STATS_EN) speculative push count
//   stat_mispredict_o     (FE_NEXT_PC_STATS_EN) mispredict pop count
//   err_o                 sticky: resolve seen with an empty queue
// ----------------------------------------------------------------------------
module fe_next_pc_gen #(
   parameter int                     PC_WIDTH    = 16,
   parameter int                     INSTR_BYTES = 2,
   parameter int                     SPEC_DEPTH  = 4,
   parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
   localparam int                    PTR_W       = $clog2(SPEC_DEPTH),
   localparam int                    CNT_W       = PTR_W + 1
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   output logic                fetch_v_o,
   input  logic                fetch_ready_i,
   output logic [PC_WIDTH-1:0] fetch_pc_o,
   input  logic                dec_v_i,
   output logic                dec_ready_o,
   input  logic [PC_WIDTH-1:0] dec_pc_i,
   input  logic                take_branch_i,
   input  logic                speculative_i,
   input  logic [PC_WIDTH-1:0] branch_target_i,
   input  logic                resolve_v_i,
   input  logic                resolve_mispredict_i,
   output logic                flush_o,
   output logic [CNT_W-1:0]    spec_count_o,
`ifdef FE_NEXT_PC_STATS_EN
   output logic [15:0]         stat_spec_o,
   output logic [15:0]         stat_mispredict_o,
`endif
   output logic                err_o
);

   logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic                fetch_v_q;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
   logic [PC_WIDTH-1:0] ckpt_q [SPEC_DEPTH];

   logic                pop, pop_ok, mispredict, full, xfer, push;
   logic [PC_WIDTH-1:0] alt_pc;

`ifdef FE_NEXT_PC_STATS_EN
   logic [15:0] stat_spec_q, stat_spec_d;
   logic [15:0] stat_mis_q, stat_mis_d;
`endif

   always_comb begin
      pop         = resolve_v_i && (cnt_q != '0);
      mispredict  = pop && resolve_mispredict_i;
      pop_ok      = pop && !resolve_mispredict_i;
      full        = (cnt_q == CNT_W'(SPEC_DEPTH));
      // A non-mispredict pop frees a slot this cycle, so a full queue can still accept.
      dec_ready_o = !(full && speculative_i && !pop_ok);
      // A mispredict kills any same-cycle decode transfer.
      xfer        = dec_v_i && dec_ready_o && !mispredict;
      push        = xfer && speculative_i;
      alt_pc      = take_branch_i ? (dec_pc_i + PC_WIDTH'(INSTR_BYTES)) : branch_target_i;

      fetch_pc_d = fetch_pc_q;
      if (mispredict)
         fetch_pc_d = ckpt_q[rd_ptr_q];
      else if (xfer && take_branch_i)
         fetch_pc_d = branch_target_i;
      else if (fetch_v_q && fetch_ready_i)
         fetch_pc_d = fetch_pc_q + PC_WIDTH'(INSTR_BYTES);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (mispredict) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         // Pointers wrap naturally since SPEC_DEPTH is a power of two.
         if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop_ok)      cnt_d = cnt_q + 1'b1;
         else if (!push && pop_ok) cnt_d = cnt_q - 1'b1;
      end

      err_d = err_q || (resolve_v_i && (cnt_q == '0));

`ifdef FE_NEXT_PC_STATS_EN
      stat_spec_d = stat_spec_q;
      stat_mis_d  = stat_mis_q;
      if (push && (stat_spec_q != 16'hFFFF))      stat_spec_d = stat_spec_q + 16'd1;
      if (mispredict && (stat_mis_q != 16'hFFFF)) stat_mis_d  = stat_mis_q + 16'd1;
`endif
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         fetch_pc_q <= RESET_PC;
         fetch_v_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
`ifdef FE_NEXT_PC_STATS_EN
         stat_spec_q <= '0;
         stat_mis_q  <= '0;
`endif
      end else begin
         fetch_pc_q <= fetch_pc_d;
         fetch_v_q  <= 1'b1;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
`ifdef FE_NEXT_PC_STATS_EN
         stat_spec_q <= stat_spec_d;
         stat_mis_q  <= stat_mis_d;
`endif
      end
   end

   // Checkpoint storage is pure data; occupancy tracking makes its reset unnecessary.
   always_ff @(posedge clk_i) begin
      if (push) ckpt_q[wr_ptr_q] <= alt_pc;
   end

   assign fetch_pc_o   = fetch_pc_q;
   assign fetch_v_o    = fetch_v_q;
   assign flush_o      = mispredict;
   assign spec_count_o = cnt_q;
   assign err_o        = err_q;
`ifdef FE_NEXT_PC_STATS_EN
   assign stat_spec_o       = stat_spec_q;
   assign stat_mispredict_o = stat_mis_q;
`endif

endmodule

// File: tb/tb_fe_next_pc_gen.sv
module tb_fe_next_pc_gen;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        fetch_v, fetch_ready;
   logic [15:0] fetch_pc;
   logic        dec_v, dec_ready;
   logic [15:0] dec_pc, target;
   logic        take, spec;
   logic        res_v, res_mis;
   logic        flush, err;
   logic [2:0]  count;
`ifdef FE_NEXT_PC_STATS_EN
   logic [15:0] stat_spec, stat_mis;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fe_next_pc_gen #(.PC_WIDTH(16), .INSTR_BYTES(2), .SPEC_DEPTH(4), .RESET_PC(16'h0000)) dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .fetch_v_o(fetch_v), .fetch_ready_i(fetch_ready), .fetch_pc_o(fetch_pc),
      .dec_v_i(dec_v), .dec_ready_o(dec_ready), .dec_pc_i(dec_pc),
      .take_branch_i(take), .speculative_i(spec), .branch_target_i(target),
      .resolve_v_i(res_v), .resolve_mispredict_i(res_mis),
      .flush_o(flush), .spec_count_o(count),
`ifdef FE_NEXT_PC_STATS_EN
      .stat_spec_o(stat_spec), .stat_mispredict_o(stat_mis),
`endif
      .err_o(err)
   );

   task automatic idle();
      dec_v = 0; take = 0; spec = 0; dec_pc = '0; target = '0;
      res_v = 0; res_mis = 0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset_n = 0; fetch_ready = 0; idle();
      tick(); tick();
      checks++; if (fetch_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc act=%h exp=0000", fetch_pc); end
      checks++; if (fetch_v !== 1'b0) begin errors++; $display("FAIL reset_fetch_v act=%b exp=0", fetch_v); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count act=%0d exp=0", count); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err act=%b exp=0", err); end
      @(negedge clk); reset_n = 1;
      tick();
      checks++; if (fetch_v !== 1'b1) begin errors++; $display("FAIL post_reset_fetch_v act=%b exp=1", fetch_v); end
   endtask

   task automatic test_sequential();
      logic [15:0] exp_seq [4];
      exp_seq = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
      @(negedge clk); fetch_ready = 1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         checks++; if (fetch_pc !== exp_seq[i]) begin errors++; $display("FAIL seq_pc[%0d] act=%h exp=%h", i, fetch_pc, exp_seq[i]); end
      end
      @(negedge clk); fetch_ready = 0;
      tick(); tick();
      checks++; if (fetch_pc !== 16'h0006) begin errors++; $display("FAIL hold_pc act=%h exp=0006", fetch_pc); end
   endtask

   task automatic test_taken_nonspec();
      @(negedge clk);
      dec_v = 1; dec_pc = 16'h0010; take = 1; spec = 0; target = 16'h0100;
      #1;
      checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL nonspec_ready act=%b exp=1", dec_ready); end
      tick();
      checks++; if (fetch_pc !== 16'h0100) begin errors++; $display("FAIL nonspec_redirect act=%h exp=0100", fetch_pc); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL nonspec_count act=%0d exp=0", count); end
      @(negedge clk); idle();
   endtask

   task automatic test_spec_mispredict();
      @(negedge clk);
      dec_v = 1; dec_pc = 16'h0020; take = 1; spec = 1; target = 16'h0008;
      tick();
      checks++; if (fetch_pc !== 16'h0008) begin errors++; $display("FAIL spec_taken_pc act=%h exp=0008", fetch_pc); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL spec_push_count act=%0d exp=1", count); end
      @(negedge clk); idle(); res_v = 1; res_mis = 1;
      #1;
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mis_flush act=%b exp=1", flush); end
      tick();
      checks++; if (fetch_pc !== 16'h0022) begin errors++; $display("FAIL mis_restore_pc act=%h exp=0022", fetch_pc); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL mis_count act=%0d exp=0", count); end
      @(negedge clk); idle(); #1;
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL flush_clear act=%b exp=0", flush); end
   endtask

   task automatic test_full_queue();
      // Four not-taken speculative branches: alternates are the targets.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         dec_v = 1; take = 0; spec = 1; dec_pc = 16'h0030 + 16'(i * 2); target = 16'h0300 + 16'(i * 16);
         tick();
      end
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count act=%0d exp=4", count); end
      checks++; if (fetch_pc !== 16'h0022) begin errors++; $display("FAIL nt_hold_pc act=%h exp=0022", fetch_pc); end
      @(negedge clk); target = 16'h0340; dec_pc = 16'h0038; #1;
      checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL full_ready act=%b exp=0", dec_ready); end
      tick();
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_stall_count act=%0d exp=4", count); end
      @(negedge clk); res_v = 1; res_mis = 0; #1;
      checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL pop_push_ready act=%b exp=1", dec_ready); end
      tick();
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL pop_push_count act=%0d exp=4", count); end
      // Oldest remaining entry must be 0x0310, which checks in-order pop and pointer wrap.
      @(negedge clk); idle(); res_v = 1; res_mis = 1;
      tick();
      checks++; if (fetch_pc !== 16'h0310) begin errors++; $display("FAIL wrap_restore_pc act=%h exp=0310", fetch_pc); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_flush_count act=%0d exp=0", count); end
      @(negedge clk); idle();
   endtask

   task automatic test_mispredict_with_dec();
      @(negedge clk);
      dec_v = 1; take = 1; spec = 1; dec_pc = 16'h003E; target = 16'h0500;
      tick();
      checks++; if (fetch_pc !== 16'h0500) begin errors++; $display("FAIL pre_mis_pc act=%h exp=0500", fetch_pc); end
      @(negedge clk);
      dec_pc = 16'h0500; target = 16'h0200; res_v = 1; res_mis = 1;
      tick();
      checks++; if (fetch_pc !== 16'h0040) begin errors++; $display("FAIL mis_dec_pc act=%h exp=0040", fetch_pc); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL mis_dec_no_push act=%0d exp=0", count); end
      @(negedge clk); idle();
   endtask

   task automatic test_empty_resolve();
      @(negedge clk); res_v = 1; res_mis = 1; #1;
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL empty_flush act=%b exp=0", flush); end
      tick();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL empty_err act=%b exp=1", err); end
      checks++; if (fetch_pc !== 16'h0040) begin errors++; $display("FAIL empty_pc act=%h exp=0040", fetch_pc); end
      @(negedge clk); idle();
      tick(); tick();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky act=%b exp=1", err); end
`ifdef FE_NEXT_PC_STATS_EN
      checks++; if (stat_mis !== 16'd3) begin errors++; $display("FAIL stat_mis act=%0d exp=3", stat_mis); end
      checks++; if (stat_spec !== 16'd7) begin errors++; $display("FAIL stat_spec act=%0d exp=7", stat_spec); end
`endif
   endtask

   task automatic test_pc_wrap();
      @(negedge clk); dec_v = 1; take = 1; spec = 0; dec_pc = 16'h0040; target = 16'hFFFE;
      tick();
      @(negedge clk); idle(); fetch_ready = 1;
      tick();
      checks++; if (fetch_pc !== 16'h0000) begin errors++; $display("FAIL pc_wrap act=%h exp=0000", fetch_pc); end
      @(negedge clk); fetch_ready = 0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk); dec_v = 1; take = 0; spec = 1; dec_pc = 16'h0002; target = 16'h0700;
      tick();
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL mid_push_count act=%0d exp=1", count); end
      @(negedge clk); idle(); reset_n = 0;
      tick();
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_reset_count act=%0d exp=0", count); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_reset_err act=%b exp=0", err); end
      @(negedge clk); reset_n = 1; res_v = 1; res_mis = 1; #1;
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mid_reset_flush act=%b exp=0", flush); end
      tick();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL mid_reset_discard act=%b exp=1", err); end
      @(negedge clk); idle();
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_taken_nonspec();
      test_spec_mispredict();
      test_full_queue();
      test_mispredict_with_dec();
      test_empty_resolve();
      test_pc_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fe_next_pc_gen.md
Name: fe_next_pc_gen

Overview:
- Front-end next-PC generator and speculative-branch checkpoint queue.
- Sits directly downstream of the front-end static branch-control stage and consumes its take-branch/speculative decisions.
- Owns the fetch PC register and redirects fetch on decode-time taken branches and on backend mispredicts.
- Checkpoints the alternate (not-chosen) PC of every speculative branch and restores it when that branch resolves as mispredicted.

Parameters:
- PC_WIDTH, 16, width of all PC/target buses.
- INSTR_BYTES, 2, sequential PC increment.
- SPEC_DEPTH, 4, checkpoint queue entries (power of 2, >=2).
- RESET_PC, 0, fetch PC loaded at reset.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous active-low reset
- fetch_v_o  out  1  fetch_pc_o valid
- fetch_ready_i  in  1  fetch/I-cache accepts fetch_pc_o
- fetch_pc_o  out  PC_WIDTH  current fetch PC (registered)
- dec_v_i  in  1  branch-control result valid
- dec_ready_o  out  1  this block accepts the dec_* bundle
- dec_pc_i  in  PC_WIDTH  PC of the decoded instruction
- take_branch_i  in  1  static branch-control take decision
- speculative_i  in  1  decision is speculative; needs a checkpoint
- branch_target_i  in  PC_WIDTH  decoded branch target
- resolve_v_i  in  1  backend resolves the oldest speculative branch
- resolve_mispredict_i  in  1  that branch was mispredicted
- flush_o  out  1  combinational: kill all younger front-end state this cycle
- spec_count_o  out  $clog2(SPEC_DEPTH)+1  queue occupancy
- err_o  out  1  sticky: resolve received with empty queue

Behaviour:
- Reset (reset_n_i=0 at posedge):
  - fetch_pc_o=RESET_PC, fetch_v_o=0, spec_count_o=0, err_o=0, queue pointers=0.
  - A reset asserted mid-operation discards all checkpoints.
- fetch_v_o=1 from the first cycle after reset deasserts; it stays 1 thereafter.
- Decode handshake:
  - A transfer occurs when dec_v_i && dec_ready_o.
  - dec_ready_o=0 only when the queue is full, speculative_i=1, and no non-mispredict pop happens this cycle.
  - Otherwise dec_ready_o=1.
- Checkpoint push on a speculative transfer:
  - take_branch_i=1: store alternate = dec_pc_i+INSTR_BYTES.
  - take_branch_i=0: store alternate = branch_target_i.
- Non-speculative transfers never push.
- Pop:
  - resolve_v_i with a non-empty queue pops the oldest entry.
  - Resolution is strictly in order.
  - Pointers wrap modulo SPEC_DEPTH.
- Mispredict (resolve_v_i && resolve_mispredict_i && non-empty queue):
  - flush_o=1 the same cycle.
  - Next cycle: fetch_pc_o = popped alternate, the whole queue is emptied (spec_count_o=0), and any same-cycle dec transfer is dropped (no push, no redirect).
- Next fetch PC, registered, in priority order:
  1. Mispredict restore.
  2. Transfer with take_branch_i=1: fetch_pc_o <= branch_target_i, independent of fetch_ready_i.
  3. fetch_v_o && fetch_ready_i: fetch_pc_o <= fetch_pc_o+INSTR_BYTES, wrapping modulo 2^PC_WIDTH.
  4. Otherwise hold.
- Simultaneous non-mispredict pop and push in the same cycle: spec_count_o is unchanged; allowed even when full.
- resolve_v_i with an empty queue: no pop, no flush, no redirect; err_o <= 1 until reset.
- Latency:
  - Redirect visible on fetch_pc_o 1 cycle after the causing event.
  - spec_count_o updates 1 cycle after push/pop.

Optional Feature:
- Macro: FE_NEXT_PC_STATS_EN.
- When defined:
  - Adds output ports stat_spec_o[15:0] (count of speculative pushes) and stat_mispredict_o[15:0] (count of mispredict pops).
  - Both counters saturate at 16'hFFFF and reset to 0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then fetch_ready_i=1 for 4 cycles -> fetch_pc_o sequence 0x0000, 0x0002, 0x0004, 0x0006; fetch_ready_i=0 holds the PC.
- Transfer dec_pc_i=0x0010, take_branch_i=1, speculative_i=0, target=0x0100 -> next fetch_pc_o=0x0100; spec_count_o stays 0.
- Backward speculative taken branch at dec_pc_i=0x0020, target=0x0008, then resolve_v_i=1, resolve_mispredict_i=1 -> flush_o=1 that cycle; next fetch_pc_o=0x0022; spec_count_o=0.
- Push 4 speculative branches (SPEC_DEPTH=4):
  - A 5th speculative dec_v_i -> dec_ready_o=0.
  - Same cycle, add resolve_v_i=1, mispredict=0 -> transfer accepted; spec_count_o stays 4; pointers wrap.
- Mispredict resolve in the same cycle as a taken dec transfer (target 0x0200), alternate 0x0040 -> next fetch_pc_o=0x0040; no push occurs.
- resolve_v_i=1 with an empty queue -> err_o=1 and remains 1; fetch_pc_o unaffected. With FE_NEXT_PC_STATS_EN defined, stat_mispredict_o does not increment.
